// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display path.
package score_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam logic [6:0]  SEG_BLANK    = 7'b1111111;
  localparam logic [6:0]  SEG_ZERO     = 7'b1000000;
  localparam int unsigned BCD_DIGITS   = 3;
  localparam logic [3:0]  ADD3_THRESH  = 4'd5;

  // Double-dabble correction: bump every nibble >= 5 so the next shift carries into the next digit.
  function automatic logic [4*BCD_DIGITS-1:0] add3_nibbles(input logic [4*BCD_DIGITS-1:0] d);
    logic [4*BCD_DIGITS-1:0] r;
    r = d;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (d[4*i +: 4] >= ADD3_THRESH) begin
        r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/score_display_seg7_decoder.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; non-decimal codes blank.
module seg7_decoder
  import score_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Combinational digit lookup.
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (digit_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Binary score to three BCD digits and three active-low 7-segment displays.
// Iterative double-dabble conversion, started whenever the score differs from the last converted
// value. Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens digits.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned SCORE_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [SCORE_W-1:0] score,
  output logic [11:0]        bcd,
  output logic [6:0]         hex2,
  output logic [6:0]         hex1,
  output logic [6:0]         hex0,
  output logic               busy,
  output logic               updated
);

  localparam int unsigned BcdW = 4 * BCD_DIGITS;
  localparam int unsigned ShW  = BcdW + SCORE_W;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LeadRst = SEG_BLANK;
`else
  localparam logic [6:0] LeadRst = SEG_ZERO;
`endif

  state_e             state_q;
  logic [SCORE_W-1:0] last_q;
  logic [ShW-1:0]     sh_q;
  logic [ShW-1:0]     sh_adj;
  logic [ShW-1:0]     sh_shift;
  logic [2:0]         cnt_q;
  logic [11:0]        bcd_q;
  logic [6:0]         hex2_q, hex1_q, hex0_q;
  logic [6:0]         seg2, seg1, seg0;
  logic [6:0]         hex2_d, hex1_d;
  logic               busy_q, updated_q;

  seg7_decoder u_dec2 (.digit_i(sh_q[ShW-1 -: 4]),  .seg_o(seg2));
  seg7_decoder u_dec1 (.digit_i(sh_q[ShW-5 -: 4]),  .seg_o(seg1));
  seg7_decoder u_dec0 (.digit_i(sh_q[ShW-9 -: 4]),  .seg_o(seg0));

  // One double-dabble step: correct the BCD nibbles, then shift the whole word left.
  always_comb begin
    sh_adj   = {add3_nibbles(sh_q[ShW-1 -: BcdW]), sh_q[SCORE_W-1:0]};
    sh_shift = {sh_adj[ShW-2:0], 1'b0};
  end

  // Leading-zero blanking applies to the displayed digits only, never to bcd.
  always_comb begin
    hex2_d = seg2;
    hex1_d = seg1;
`ifdef LEADING_ZERO_BLANK_EN
    if (sh_q[ShW-1 -: 4] == 4'd0) begin
      hex2_d = SEG_BLANK;
      if (sh_q[ShW-5 -: 4] == 4'd0) hex1_d = SEG_BLANK;
    end
`endif
  end

  // Conversion FSM with registered outputs, written only in StDone so the display never glitches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      last_q    <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      hex2_q    <= LeadRst;
      hex1_q    <= LeadRst;
      hex0_q    <= SEG_ZERO;
      busy_q    <= 1'b0;
      updated_q <= 1'b0;
    end else begin
      updated_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (score != last_q) begin
            last_q  <= score;
            sh_q    <= {{BcdW{1'b0}}, score};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          sh_q  <= sh_shift;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= StDone;
        end
        StDone: begin
          bcd_q     <= sh_q[ShW-1 -: BcdW];
          hex2_q    <= hex2_d;
          hex1_q    <= hex1_d;
          hex0_q    <= seg0;
          updated_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bcd     = bcd_q;
  assign hex2    = hex2_q;
  assign hex1    = hex1_q;
  assign hex0    = hex0_q;
  assign busy    = busy_q;
  assign updated = updated_q;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: vector table plus scoreboard queue of expected displays.
module tb_score_display;

  logic        clk;
  logic        resetn;
  logic [7:0]  score;
  logic [11:0] bcd;
  logic [6:0]  hex2, hex1, hex0;
  logic        busy, updated;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  score;
    logic [11:0] bcd;
    logic [6:0]  h2;
    logic [6:0]  h1;
    logic [6:0]  h0;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[9];

  score_display #(.SCORE_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .score  (score),
    .bcd    (bcd),
    .hex2   (hex2),
    .hex1   (hex1),
    .hex0   (hex0),
    .busy   (busy),
    .updated(updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected record from a score and its hand-written BCD value.
  function automatic vec_t mk(input logic [7:0] s, input logic [11:0] b);
    vec_t v;
    v.score = s;
    v.bcd   = b;
    v.h2    = seg_of(b[11:8]);
    v.h1    = seg_of(b[7:4]);
    v.h0    = seg_of(b[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    if (b[11:8] == 4'd0) begin
      v.h2 = 7'b1111111;
      if (b[7:4] == 4'd0) v.h1 = 7'b1111111;
    end
`endif
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    vec_t z;
    z = mk(8'd0, 12'h000);
    chk({nm, "_bcd"},  32'(bcd),  32'(z.bcd));
    chk({nm, "_hex2"}, 32'(hex2), 32'(z.h2));
    chk({nm, "_hex1"}, 32'(hex1), 32'(z.h1));
    chk({nm, "_hex0"}, 32'(hex0), 32'(z.h0));
    chk({nm, "_busy"}, 32'(busy), 32'(0));
    chk({nm, "_upd"},  32'(updated), 32'(0));
  endtask

  // Drive a new score ahead of the capture edge and record the expected display.
  task automatic drive(input vec_t v);
    @(negedge clk);
    score = v.score;
    sb_q.push_back(v);
  endtask

  // Wait (bounded) for the update pulse, check its latency and pop the scoreboard.
  task automatic wait_update(input string nm, input int exp_n);
    int n;
    vec_t e;
    n = 0;
    while (n < 25) begin
      @(posedge clk); #1;
      n++;
      if (updated) break;
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_n));
    if (sb_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_bcd"},  32'(bcd),  32'(e.bcd));
      chk({nm, "_hex2"}, 32'(hex2), 32'(e.h2));
      chk({nm, "_hex1"}, 32'(hex1), 32'(e.h1));
      chk({nm, "_hex0"}, 32'(hex0), 32'(e.h0));
      chk({nm, "_busy_last"}, 32'(busy), 32'(0));
    end
  endtask

  task automatic run_one(input string nm, input vec_t v);
    drive(v);
    @(posedge clk); #1;
    chk({nm, "_busy_rise"}, 32'(busy), 32'(1));
    wait_update(nm, 9);
    @(posedge clk); #1;
    chk({nm, "_pulse_end"}, 32'(updated), 32'(0));
    chk({nm, "_idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int seen;
    vecs[0] = mk(8'd1,   12'h001);
    vecs[1] = mk(8'd255, 12'h255);
    vecs[2] = mk(8'd0,   12'h000);
    vecs[3] = mk(8'd99,  12'h099);
    vecs[4] = mk(8'd100, 12'h100);
    vecs[5] = mk(8'd7,   12'h007);
    vecs[6] = mk(8'd105, 12'h105);
    vecs[7] = mk(8'd128, 12'h128);
    vecs[8] = mk(8'd9,   12'h009);

    // Reset, then release with score equal to the reset value of last.
    score  = 8'd0;
    resetn = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (busy || updated) seen = 1;
    end
    chk("no_conv_after_reset", 32'(seen), 32'(0));
    check_reset_outputs("post_reset");

    foreach (vecs[i]) run_one($sformatf("vec%0d_s%0d", i, vecs[i].score), vecs[i]);

    // Score held: nothing happens.
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (busy || updated) seen = 1;
    end
    chk("hold_quiet", 32'(seen), 32'(0));

    // Score change mid-conversion is deferred to the next capture at E10.
    drive(mk(8'd10, 12'h010));
    @(posedge clk); #1;
    chk("chg_busy_rise", 32'(busy), 32'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    score = 8'd11;
    sb_q.push_back(mk(8'd11, 12'h011));
    wait_update("chg_first", 6);
    @(posedge clk); #1;
    chk("chg_recapture_busy", 32'(busy), 32'(1));
    chk("chg_pulse_end", 32'(updated), 32'(0));
    wait_update("chg_second", 9);

    // Asynchronous reset mid-shift abandons the conversion.
    @(posedge clk); #1;
    @(negedge clk);
    score = 8'd200;
    repeat (6) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    score  = 8'd42;
    resetn = 1'b1;
    sb_q.push_back(mk(8'd42, 12'h042));
    @(posedge clk); #1;
    chk("after_reset_busy", 32'(busy), 32'(1));
    wait_update("after_reset", 9);

    chk("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
